// File: rtl/linear_sensor_pkg.sv
// Shared types and LFSR tap masks for the linear sensor emulator.
package linear_sensor_pkg;

    typedef enum logic [1:0] {
        PAT_RAMP     = 2'd0,
        PAT_CONSTANT = 2'd1,
        PAT_LFSR     = 2'd2,
        PAT_CHECKER  = 2'd3
    } pattern_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_READOUT = 1'b1
    } state_t;

    localparam logic [31:0] LFSR_TAPS_2  = 32'h0000_0003;
    localparam logic [31:0] LFSR_TAPS_3  = 32'h0000_0006;
    localparam logic [31:0] LFSR_TAPS_4  = 32'h0000_000C;
    localparam logic [31:0] LFSR_TAPS_5  = 32'h0000_0014;
    localparam logic [31:0] LFSR_TAPS_6  = 32'h0000_0030;
    localparam logic [31:0] LFSR_TAPS_7  = 32'h0000_0060;
    localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] LFSR_TAPS_9  = 32'h0000_0110;
    localparam logic [31:0] LFSR_TAPS_10 = 32'h0000_0240;
    localparam logic [31:0] LFSR_TAPS_11 = 32'h0000_0500;
    localparam logic [31:0] LFSR_TAPS_12 = 32'h0000_0829;
    localparam logic [31:0] LFSR_TAPS_13 = 32'h0000_100D;
    localparam logic [31:0] LFSR_TAPS_14 = 32'h0000_2015;
    localparam logic [31:0] LFSR_TAPS_15 = 32'h0000_6000;
    localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_D008;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    // Feedback mask (bit n = register bit n) for a shift-left Fibonacci LFSR.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            2:       taps = LFSR_TAPS_2;
            3:       taps = LFSR_TAPS_3;
            4:       taps = LFSR_TAPS_4;
            5:       taps = LFSR_TAPS_5;
            6:       taps = LFSR_TAPS_6;
            7:       taps = LFSR_TAPS_7;
            8:       taps = LFSR_TAPS_8;
            9:       taps = LFSR_TAPS_9;
            10:      taps = LFSR_TAPS_10;
            11:      taps = LFSR_TAPS_11;
            12:      taps = LFSR_TAPS_12;
            13:      taps = LFSR_TAPS_13;
            14:      taps = LFSR_TAPS_14;
            15:      taps = LFSR_TAPS_15;
            16:      taps = LFSR_TAPS_16;
            default: taps = LFSR_TAPS_32;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/linear_sensor_emulator_sync_edge_detect.sv
// Multi-flop synchronizer with a one-cycle rising-edge pulse on the synchronized signal.
module sync_edge_detect
    import linear_sensor_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/linear_sensor_emulator.sv
// Linear image sensor emulator: replays test patterns on the driver's clock/SI.
// Optional integration-period measurement: LINEAR_SENSOR_EMU_INTEG_MEASURE_EN.
module linear_sensor_emulator
    import linear_sensor_pkg::*;
#(
    parameter int NUMBER_OF_PIXEL = 128,
    parameter int PIXEL_WIDTH     = 12,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                               master_clock,
    input  logic                               reset,
    input  logic                               sensor_clk,
    input  logic                               sensor_si,
    input  logic [1:0]                         pattern_sel,
    input  logic [PIXEL_WIDTH-1:0]             pattern_seed,
    output logic [PIXEL_WIDTH-1:0]             pixel_data,
    output logic                               pixel_valid,
    output logic [$clog2(NUMBER_OF_PIXEL)-1:0] pixel_index,
    output logic                               frame_active,
    output logic                               frame_done,
    output logic                               si_error,
    output logic [15:0]                        frame_count
`ifdef LINEAR_SENSOR_EMU_INTEG_MEASURE_EN
    ,
    output logic [31:0]                        integ_nclk
`endif
);

    localparam int IDX_W = $clog2(NUMBER_OF_PIXEL);
    localparam int STG   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUMBER_OF_PIXEL - 1);
    localparam logic [PIXEL_WIDTH-1:0] LFSR_MASK = PIXEL_WIDTH'(lfsr_taps(PIXEL_WIDTH));

    logic                   clk_edge;
    logic [STG-1:0]         si_sync;
    logic                   si_s;
    state_t                 state;
    logic [PIXEL_WIDTH-1:0] lfsr;
    logic [PIXEL_WIDTH-1:0] seed_nz;
    logic [PIXEL_WIDTH-1:0] start_val;
    logic [PIXEL_WIDTH-1:0] adv_val;
    logic                   do_start;
    logic                   do_adv;
    logic                   do_done;
    logic                   do_err;

    sync_edge_detect #(.STAGES(STG)) u_clk_sync (
        .clk      (master_clock),
        .rst      (reset),
        .async_in (sensor_clk),
        .rise     (clk_edge)
    );

    // Same depth as the clock path so SI lines up with the detected edge.
    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) si_sync <= '0;
        else       si_sync <= {si_sync[STG-2:0], sensor_si};
    end
    assign si_s = si_sync[STG-1];

    function automatic logic [PIXEL_WIDTH-1:0] lfsr_step(input logic [PIXEL_WIDTH-1:0] v);
        return {v[PIXEL_WIDTH-2:0], ^(v & LFSR_MASK)};
    endfunction

    function automatic logic [PIXEL_WIDTH-1:0] pattern_value(
        input pattern_t               sel,
        input logic [PIXEL_WIDTH-1:0] seed,
        input logic [IDX_W-1:0]       idx,
        input logic [PIXEL_WIDTH-1:0] lfsr_val
    );
        logic [PIXEL_WIDTH-1:0] v;
        case (sel)
            PAT_RAMP:     v = seed + PIXEL_WIDTH'(idx);
            PAT_CONSTANT: v = seed;
            PAT_LFSR:     v = lfsr_val;
            PAT_CHECKER:  v = idx[0] ? ~seed : seed;
            default:      v = seed;
        endcase
        return v;
    endfunction

    always_comb begin
        seed_nz   = (pattern_seed == '0) ? PIXEL_WIDTH'(1) : pattern_seed;
        start_val = pattern_value(pattern_t'(pattern_sel), pattern_seed, '0, seed_nz);
        adv_val   = pattern_value(pattern_t'(pattern_sel), pattern_seed, pixel_index + 1'b1, lfsr);
        do_start  = 1'b0;
        do_adv    = 1'b0;
        do_done   = 1'b0;
        do_err    = 1'b0;
        if (clk_edge) begin
            case (state)
                ST_IDLE: do_start = si_s;
                ST_READOUT: begin
                    if (pixel_index == LAST_IDX) begin
                        do_done  = 1'b1;
                        do_start = si_s;
                    end else if (si_s) begin
                        do_err   = 1'b1;
                        do_start = 1'b1;
                    end else begin
                        do_adv   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // frame_active stays high through the frame_done cycle, then drops once back in IDLE.
    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            pixel_data   <= '0;
            pixel_index  <= '0;
            pixel_valid  <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            si_error     <= 1'b0;
            frame_count  <= '0;
            lfsr         <= PIXEL_WIDTH'(1);
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            si_error    <= do_err;
            if (do_start) begin
                state        <= ST_READOUT;
                pixel_valid  <= 1'b1;
                pixel_index  <= '0;
                pixel_data   <= start_val;
                lfsr         <= lfsr_step(seed_nz);
                frame_active <= 1'b1;
            end else if (do_adv) begin
                pixel_valid <= 1'b1;
                pixel_index <= pixel_index + 1'b1;
                pixel_data  <= adv_val;
                lfsr        <= lfsr_step(lfsr);
            end else if (state == ST_IDLE) begin
                frame_active <= 1'b0;
            end
            if (do_done) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 16'd1;
                if (!do_start) state <= ST_IDLE;
            end
        end
    end

`ifdef LINEAR_SENSOR_EMU_INTEG_MEASURE_EN
    logic [31:0] integ_cnt;
    logic        seen_start;

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            integ_cnt  <= '0;
            seen_start <= 1'b0;
            integ_nclk <= '0;
        end else if (do_start) begin
            if (seen_start) integ_nclk <= integ_cnt;
            seen_start <= 1'b1;
            integ_cnt  <= 32'd1;
        end else if (integ_cnt != '1) begin
            integ_cnt <= integ_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_linear_sensor_emulator.sv
// Scoreboard bench for linear_sensor_emulator with a behavioural frame model.
module tb_linear_sensor_emulator;

    localparam int N = 128;
    localparam int W = 12;
    localparam int MASK = (1 << W) - 1;
    localparam int EV_PIX = 0, EV_DONE = 1, EV_ERR = 2;

    logic          master_clock = 1'b0;
    logic          reset;
    logic          sensor_clk;
    logic          sensor_si;
    logic [1:0]    pattern_sel;
    logic [W-1:0]  pattern_seed;
    logic [W-1:0]  pixel_data;
    logic          pixel_valid;
    logic [6:0]    pixel_index;
    logic          frame_active;
    logic          frame_done;
    logic          si_error;
    logic [15:0]   frame_count;
`ifdef LINEAR_SENSOR_EMU_INTEG_MEASURE_EN
    logic [31:0]   integ_nclk;
`endif

    linear_sensor_emulator #(.NUMBER_OF_PIXEL(N), .PIXEL_WIDTH(W), .SYNC_STAGES(2)) dut (
        .master_clock (master_clock),
        .reset        (reset),
        .sensor_clk   (sensor_clk),
        .sensor_si    (sensor_si),
        .pattern_sel  (pattern_sel),
        .pattern_seed (pattern_seed),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_index  (pixel_index),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .si_error     (si_error),
        .frame_count  (frame_count)
`ifdef LINEAR_SENSOR_EMU_INTEG_MEASURE_EN
        ,
        .integ_nclk   (integ_nclk)
`endif
    );

    always #5 master_clock = ~master_clock;

    typedef struct {
        int kind;
        int idx;
        int data;
    } ev_t;

    ev_t exp_q[$];
    int  cap_q[$];
    int  tests = 0;
    int  fails = 0;

    // Reference model state
    bit  m_in_frame = 0;
    int  m_idx = 0;
    int  m_lfsr = 1;
    int  m_count = 0;
    int  tap_pos[4] = '{12, 6, 4, 1};   // x^12 + x^6 + x^4 + x + 1

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lfsr_adv(input int v);
        int fb = 0;
        foreach (tap_pos[i]) fb ^= (v >> (tap_pos[i] - 1)) & 1;
        return ((v << 1) | fb) & MASK;
    endfunction

    function automatic int pat_val(input int idx);
        int seed = int'(pattern_seed);
        case (pattern_sel)
            2'd0:    return (seed + idx) & MASK;
            2'd1:    return seed;
            2'd2:    return m_lfsr;
            default: return (idx % 2 == 1) ? (~seed & MASK) : seed;
        endcase
    endfunction

    task automatic push_ev(input int kind, input int idx, input int data);
        ev_t e;
        e.kind = kind; e.idx = idx; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic model_start();
        m_in_frame = 1;
        m_idx = 0;
        m_lfsr = (pattern_seed == 0) ? 1 : int'(pattern_seed);
        push_ev(EV_PIX, 0, pat_val(0));
    endtask

    task automatic model_edge(input bit si);
        if (!m_in_frame) begin
            if (si) model_start();
        end else if (m_idx == N - 1) begin
            m_count = (m_count + 1) & 16'hFFFF;
            push_ev(EV_DONE, 0, m_count);
            m_in_frame = 0;
            if (si) model_start();
        end else if (si) begin
            push_ev(EV_ERR, 0, 0);
            model_start();
        end else begin
            m_idx++;
            m_lfsr = lfsr_adv(m_lfsr);
            push_ev(EV_PIX, m_idx, pat_val(m_idx));
        end
    endtask

    // One sensor clock period: exactly 8 master clock cycles.
    task automatic sensor_edge(input bit si);
        @(posedge master_clock); #1 sensor_si = si;
        @(posedge master_clock); #1 sensor_clk = 1'b1;
        model_edge(si);
        repeat (3) @(posedge master_clock);
        #1 sensor_clk = 1'b0;
        repeat (3) @(posedge master_clock);
    endtask

    task automatic settle();
        repeat (6) @(posedge master_clock);
        #1;
    endtask

    task automatic expect_event(input string name, input int kind, input int idx, input int data);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: got unexpected event idx=%0d data=0x%0h, required none", name, idx, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.idx != idx || e.data != data) begin
                fails++;
                $display("FAIL %s: got kind=%0d idx=%0d data=0x%0h, required kind=%0d idx=%0d data=0x%0h",
                         name, kind, idx, data, e.kind, e.idx, e.data);
            end
        end
    endtask

    always @(negedge master_clock) begin
        if (!reset) begin
            if (frame_done) expect_event("frame_done", EV_DONE, 0, int'(frame_count));
            if (si_error)   expect_event("si_error", EV_ERR, 0, 0);
            if (pixel_valid) begin
                expect_event("pixel", EV_PIX, int'(pixel_index), int'(pixel_data));
                cap_q.push_back(int'(pixel_data));
            end
            if (pixel_valid || frame_done) check("frame_active_on", int'(frame_active), 1);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},   int'(pixel_data), 0);
        check({tag, "_index"},  int'(pixel_index), 0);
        check({tag, "_pulses"}, int'({pixel_valid, frame_done, si_error}), 0);
        check({tag, "_active"}, int'(frame_active), 0);
        check({tag, "_count"},  int'(frame_count), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dups;
        reset = 1'b1; sensor_clk = 1'b0; sensor_si = 1'b0;
        pattern_sel = 2'd0; pattern_seed = '0;
        repeat (3) @(posedge master_clock);
        #1 check_all_zero("reset");
        reset = 1'b0;
        repeat (3) @(posedge master_clock);

        // Full ramp frame from 0x100
        pattern_sel = 2'd0; pattern_seed = 12'h100;
        sensor_edge(1);
        repeat (N) sensor_edge(0);
        settle();
        check("ramp_count", int'(frame_count), 1);
        check("ramp_idle_active", int'(frame_active), 0);

        // SI mid-frame at pixel 40
        pattern_sel = 2'd1; pattern_seed = W'($urandom);
        sensor_edge(1);
        repeat (40) sensor_edge(0);
        sensor_edge(1);
        settle();
        check("err_count", int'(frame_count), 1);
        repeat (N) sensor_edge(0);
        settle();
        check("err_frame_count", int'(frame_count), 2);

        // Checker with back-to-back restart on the closing edge
        pattern_sel = 2'd3; pattern_seed = 12'hA5A;
        cap_q.delete();
        sensor_edge(1);
        repeat (N - 1) sensor_edge(0);
        sensor_edge(1);
        repeat (N) sensor_edge(0);
        settle();
        check("checker_count", int'(frame_count), 4);
        check("checker_px1", cap_q[1], 12'h5A5);

        // LFSR with seed 0
        pattern_sel = 2'd2; pattern_seed = '0;
        cap_q.delete();
        sensor_edge(1);
        repeat (N) sensor_edge(0);
        settle();
        check("lfsr_npix", cap_q.size(), N);
        check("lfsr_first", cap_q[0], 1);
        dups = 0;
        for (int i = 0; i < cap_q.size(); i++)
            for (int j = i + 1; j < cap_q.size(); j++)
                if (cap_q[i] == cap_q[j]) dups++;
        check("lfsr_repeats", dups, 0);

        // Randomised frames with occasional SI faults
        for (int f = 0; f < 6; f++) begin
            pattern_sel = 2'($urandom_range(0, 3));
            pattern_seed = W'($urandom);
            repeat ($urandom_range(1, 3)) sensor_edge(0);
            sensor_edge(1);
            for (int k = 0; k < 400 && m_in_frame; k++)
                sensor_edge($urandom_range(0, 199) == 0);
        end
        settle();
        check("rand_count", int'(frame_count), m_count);

        // Reset at pixel 60
        pattern_sel = 2'd0; pattern_seed = W'($urandom);
        if (m_in_frame) begin
            while (m_in_frame) sensor_edge(0);
        end
        sensor_edge(1);
        repeat (60) sensor_edge(0);
        @(posedge master_clock); #1 reset = 1'b1;
        exp_q.delete(); m_in_frame = 0; m_count = 0;
        repeat (2) @(posedge master_clock);
        #1 check_all_zero("midreset");
        reset = 1'b0;
        repeat (10) sensor_edge(0);
        settle();
        check("post_reset_active", int'(frame_active), 0);
        check("post_reset_count", int'(frame_count), 0);

`ifdef LINEAR_SENSOR_EMU_INTEG_MEASURE_EN
        // Frame starts exactly 2500 sensor periods (20000 master clocks) apart
        sensor_edge(1);
        check("integ_first", int'(integ_nclk), 0);
        repeat (2499) sensor_edge(0);
        sensor_edge(1);
        settle();
        check("integ_period", int'(integ_nclk), 20000);
        while (m_in_frame) sensor_edge(0);
`endif

        settle();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/linear_sensor_emulator.md
LINEAR_SENSOR_EMULATOR -- requirements
Module: linear_sensor_emulator

Interface
REQ-001 Parameter NUMBER_OF_PIXEL, default 128, pixels per frame.
REQ-002 Parameter PIXEL_WIDTH, default 12, pixel data width in bits.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flops per async input (minimum 2).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 master_clock  in  1  system clock; all state on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 sensor_clk  in  1  sensor clock from the driver, asynchronous to master_clock.
REQ-008 sensor_si  in  1  start-integration pulse from the driver, asynchronous.
REQ-009 pattern_sel  in  2  0 ramp, 1 constant, 2 LFSR, 3 checker; quasi-static.
REQ-010 pattern_seed  in  PIXEL_WIDTH  base value for all patterns.
REQ-011 pixel_data  out  PIXEL_WIDTH  current emulated pixel value.
REQ-012 pixel_valid  out  1  one-cycle pulse per pixel output.
REQ-013 pixel_index  out  $clog2(NUMBER_OF_PIXEL)  index of pixel_data.
REQ-014 frame_active  out  1  high while a readout is in progress.
REQ-015 frame_done  out  1  one-cycle pulse after the final clock of a frame.
REQ-016 si_error  out  1  one-cycle pulse when SI is sampled mid-frame.
REQ-017 frame_count  out  16  completed frames, wraps 0xFFFF->0.

Function
REQ-018 Both inputs SHALL pass through SYNC_STAGES flops; a "clock edge" is synchronized sensor_clk 0->1, detected in one master_clock cycle.
REQ-019 SI SHALL be sampled only at a detected clock edge, using the synchronized SI value in that same cycle.
REQ-020 States: IDLE, READOUT; reset state IDLE.
REQ-021 IDLE + edge with SI=1 -> READOUT, index 0; pixel_valid pulses the following cycle with pixel_index=0.
REQ-022 READOUT + edge with SI=0 and index<NUMBER_OF_PIXEL-1 -> index+1, pixel_valid pulse next cycle.
REQ-023 READOUT + edge with index=NUMBER_OF_PIXEL-1 -> IDLE, frame_done pulse next cycle, frame_count+1; if SI=1 at that edge, frame_done SHALL still pulse and a new frame SHALL start at index 0 (no error).
REQ-024 READOUT + edge with SI=1 and index<NUMBER_OF_PIXEL-1 -> si_error pulse, restart at index 0, frame_count unchanged.
REQ-025 IDLE + edge with SI=0 SHALL produce no output activity.
REQ-026 Patterns: ramp = seed+index modulo 2^PIXEL_WIDTH; constant = seed; checker = seed at even index, ~seed at odd; LFSR = maximal-length Fibonacci LFSR loaded with seed (0 replaced by 1) at frame start, advanced once per pixel.
REQ-027 pixel_data and pixel_index SHALL hold their last value between pulses.
REQ-028 frame_active SHALL be high from the cycle of the first pixel_valid through the cycle of frame_done.

Reset
REQ-029 Reset SHALL clear synchronizers, state to IDLE, all outputs and frame_count to 0, LFSR to 1.
REQ-030 Reset mid-frame SHALL abort without frame_done; the next frame needs a new SI.

Configuration
REQ-031 Macro LINEAR_SENSOR_EMU_INTEG_MEASURE_EN SHALL, when defined, add output integ_nclk (32 bits): master_clock cycles between consecutive frame starts, updated at each frame start (saturating at 0xFFFFFFFF, 0 until the second start).
REQ-032 Without the macro, neither port nor counter SHALL exist.

Structure
REQ-033 Package linear_sensor_pkg SHALL hold the pattern_sel enum, the state enum and the LFSR tap constants per PIXEL_WIDTH.
REQ-034 One sub-module, sync_edge_detect (synchronizer plus rising-edge pulse), SHALL be instantiated for sensor_clk; SI uses its synchronized output only.

Verification
REQ-035 SI=1 across edge 1, 129 clock edges, ramp seed 0x100 -> 128 pulses with data 0x100..0x17F, one frame_done, frame_count=1.
REQ-036 SI re-asserted at pixel 40 -> si_error one cycle, next pulse index 0, frame_count unchanged.
REQ-037 SI=1 on edge 129 -> frame_done plus immediate restart, index 0 next, no si_error.
REQ-038 Checker seed 0xA5A -> data alternates 0xA5A/0x5A5; LFSR seed 0 -> first value 1, no repeat within 128 pixels.
REQ-039 Reset asserted at pixel 60 -> all outputs 0, no frame_done; clock edges with SI=0 -> no pulses.
REQ-040 With macro, SI period 20000 master clocks -> integ_nclk=20000 after the second start.
